// File: rtl/delay_sum_pkg.sv
// Shared sizing helpers and the output clamp for the delay-and-sum beamformer.
package delay_sum_pkg;

  localparam int LATENCY = 3;
  localparam int SAT_W   = 64;

  typedef logic signed [SAT_W-1:0] sat_word_t;

  function automatic int SUM_BITS(input int bits_audio, input int num_mics);
    return bits_audio + $clog2(num_mics) + 1;
  endfunction

  // Clamp a sign-extended value into a signed field of the given width.
  function automatic sat_word_t saturate(input sat_word_t val, input int bits);
    sat_word_t one;
    sat_word_t hi;
    sat_word_t lo;
    one = 1;
    hi  = (one <<< (bits - 1)) - one;
    lo  = -hi - one;
    if (val > hi)
      return hi;
    else if (val < lo)
      return lo;
    else
      return val;
  endfunction

endpackage

// File: rtl/delay_line_ch.sv
// One channel: circular delay RAM with registered read, zero-delay bypass and enable masking.
module delay_line_ch #(
  parameter int BITS_AUDIO = 24,
  parameter int DEPTH      = 2048,
  parameter int DELAY_BITS = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DELAY_BITS-1:0]        wr_addr,
  input  logic [DELAY_BITS-1:0]        rd_addr,
  input  logic signed [BITS_AUDIO-1:0] sample,
  input  logic                         bypass,
  input  logic                         enable,
  output logic signed [BITS_AUDIO-1:0] data
);

  logic [BITS_AUDIO-1:0] mem [DEPTH];
  logic [BITS_AUDIO-1:0] ram_q;
  logic [BITS_AUDIO-1:0] smp_q;
  logic                  byp_q;
  logic                  en_q;

  // Read-first: the read sees the old word even if the addresses ever matched.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= sample;
      ram_q        <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      byp_q <= 1'b0;
      en_q  <= 1'b0;
    end else if (wr_en) begin
      smp_q <= sample;
      byp_q <= bypass;
      en_q  <= enable;
    end
  end

  assign data = en_q ? (byp_q ? smp_q : ram_q) : '0;

endmodule

// File: rtl/delay_sum_array.sv
// N-channel delay-and-sum beamformer: per-channel delay lines, masked sum, shift and clamp.
// Fixed 3-cycle latency from valid_in to valid_out; no backpressure, samples are cycle-driven.
module delay_sum_array
  import delay_sum_pkg::*;
#(
  parameter int NUM_MICS   = 4,
  parameter int BITS_AUDIO = 24,
  parameter int DEPTH      = 2048,
  parameter int DELAY_BITS = $clog2(DEPTH),
  parameter int OUT_SHIFT  = $clog2(NUM_MICS)
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           valid_in,
  input  logic [NUM_MICS*BITS_AUDIO-1:0] audio_in,
  input  logic                           delay_load_in,
  input  logic [NUM_MICS*DELAY_BITS-1:0] delays_in,
  input  logic [NUM_MICS-1:0]            ch_en_in,
  output logic [BITS_AUDIO-1:0]          audio_out,
  output logic                           valid_out,
  output logic                           sat_out,
  output logic                           primed_out
);

  localparam int SW = SUM_BITS(BITS_AUDIO, NUM_MICS);

  logic [DELAY_BITS-1:0]          wr_ptr;
  logic [DELAY_BITS:0]            fill_cnt;
  logic [NUM_MICS*DELAY_BITS-1:0] delays_q;
  logic [NUM_MICS-1:0]            ch_en_q;
  logic [NUM_MICS-1:0]            ready;
  logic                           primed;
  logic [LATENCY-2:0]             v_pipe;

  logic signed [BITS_AUDIO-1:0] ch_dat [NUM_MICS];
  logic signed [SW-1:0]         sum_nxt;
  logic signed [SW-1:0]         sum_q;
  sat_word_t                    shifted;
  sat_word_t                    clamped;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      delays_q <= '0;
      ch_en_q  <= '1;
    end else if (delay_load_in) begin
      delays_q <= delays_in;
      ch_en_q  <= ch_en_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (valid_in) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill_cnt != (DELAY_BITS+1)'(DEPTH))
        fill_cnt <= fill_cnt + 1'b1;
    end
  end

  for (genvar m = 0; m < NUM_MICS; m++) begin : g_ch
    logic [DELAY_BITS-1:0] d;
    assign d        = delays_q[m*DELAY_BITS +: DELAY_BITS];
    // A disabled channel never holds back priming.
    assign ready[m] = (fill_cnt >= {1'b0, d}) || !ch_en_q[m];

    delay_line_ch #(
      .BITS_AUDIO (BITS_AUDIO),
      .DEPTH      (DEPTH),
      .DELAY_BITS (DELAY_BITS)
    ) u_line (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .wr_en   (valid_in),
      .wr_addr (wr_ptr),
      .rd_addr (wr_ptr - d),
      .sample  (audio_in[m*BITS_AUDIO +: BITS_AUDIO]),
      .bypass  (d == '0),
      .enable  (ch_en_q[m]),
      .data    (ch_dat[m])
    );
  end

  assign primed = &ready;

  always_comb begin
    sum_nxt = '0;
    for (int m = 0; m < NUM_MICS; m++)
      sum_nxt = sum_nxt + SW'(ch_dat[m]);
  end

  assign shifted = SAT_W'(sum_q >>> OUT_SHIFT);
  assign clamped = saturate(shifted, BITS_AUDIO);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_pipe     <= '0;
      sum_q      <= '0;
      audio_out  <= '0;
      valid_out  <= 1'b0;
      sat_out    <= 1'b0;
      primed_out <= 1'b0;
    end else begin
      v_pipe     <= {v_pipe[0], valid_in & primed};
      valid_out  <= v_pipe[1];
      primed_out <= primed;
      if (v_pipe[0])
        sum_q <= sum_nxt;
      if (v_pipe[1]) begin
        audio_out <= clamped[BITS_AUDIO-1:0];
        sat_out   <= (clamped != shifted);
      end
    end
  end

endmodule

// File: tb/tb_delay_sum_array.sv
// Directed bench for delay_sum_array: three instances cover the default, unshifted and shallow-RAM builds.
module tb_delay_sum_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        load = 1'b0;
  logic [95:0] audio = '0;
  logic [43:0] delays = '0;
  logic [15:0] delays_w = '0;
  logic [3:0]  ch_en = 4'hf;

  logic [23:0] d_aud, s_aud, w_aud;
  logic        d_vld, s_vld, w_vld;
  logic        d_sat, s_sat, w_sat;
  logic        d_prm, s_prm, w_prm;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  delay_sum_array u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .audio_in(audio),
    .delay_load_in(load), .delays_in(delays), .ch_en_in(ch_en),
    .audio_out(d_aud), .valid_out(d_vld), .sat_out(d_sat), .primed_out(d_prm)
  );

  delay_sum_array #(.OUT_SHIFT(0)) u_sat (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .audio_in(audio),
    .delay_load_in(load), .delays_in(delays), .ch_en_in(ch_en),
    .audio_out(s_aud), .valid_out(s_vld), .sat_out(s_sat), .primed_out(s_prm)
  );

  delay_sum_array #(.DEPTH(16)) u_wrap (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .audio_in(audio),
    .delay_load_in(load), .delays_in(delays_w), .ch_en_in(ch_en),
    .audio_out(w_aud), .valid_out(w_vld), .sat_out(w_sat), .primed_out(w_prm)
  );

  function automatic logic [43:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {11'(d3), 11'(d2), 11'(d1), 11'(d0)};
  endfunction

  function automatic logic [95:0] all4(input logic [23:0] x);
    return {x, x, x, x};
  endfunction

  task automatic do_reset();
    valid    = 1'b0;
    load     = 1'b0;
    audio    = '0;
    delays   = '0;
    delays_w = '0;
    ch_en    = 4'hf;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [43:0] d, input logic [15:0] dw, input logic [3:0] en);
    @(negedge clk);
    delays   = d;
    delays_w = dw;
    ch_en    = en;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b0;
    load  = 1'b0;
    rst_n = 1'b0;
    #3;
    n_checks++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", d_vld); end
    n_checks++; if (d_aud !== 24'h0) begin n_fail++; $display("FAIL reset_audio got %h exp 000000", d_aud); end
    n_checks++; if (d_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", d_sat); end
    n_checks++; if (d_prm !== 1'b0) begin n_fail++; $display("FAIL reset_primed got %b exp 0", d_prm); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Delays reset to zero, so priming needs no history.
    n_checks++; if (d_prm !== 1'b1) begin n_fail++; $display("FAIL reset_primed_after got %b exp 1", d_prm); end
  endtask

  task automatic test_basic_delay();
    logic [23:0] exp_a;
    logic        exp_v;
    int          j;
    do_reset();
    do_load(pk(0, 1, 2, 3), '0, 4'hf);
    @(negedge clk);
    n_checks++; if (d_prm !== 1'b0) begin n_fail++; $display("FAIL basic_unprimed got %b exp 0", d_prm); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      j     = i - 3;
      exp_v = (j >= 3) && (j < 12);
      n_checks++; if (d_vld !== exp_v) begin n_fail++; $display("FAIL basic_valid j=%0d got %b exp %b", j, d_vld, exp_v); end
      if (exp_v) begin
        exp_a = 24'(4 * j - 6);
        n_checks++; if (d_aud !== exp_a) begin n_fail++; $display("FAIL basic_audio j=%0d got %h exp %h", j, d_aud, exp_a); end
        n_checks++; if (d_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat j=%0d got %b exp 0", j, d_sat); end
      end
      valid = (i < 12);
      audio = all4(24'(4 * i));
    end
    n_checks++; if (d_prm !== 1'b1) begin n_fail++; $display("FAIL basic_primed got %b exp 1", d_prm); end
  endtask

  task automatic test_masking();
    logic exp_v;
    do_reset();
    do_load(pk(0, 100, 0, 0), '0, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_v = (i == 3);
      n_checks++; if (d_vld !== exp_v) begin n_fail++; $display("FAIL mask_valid i=%0d got %b exp %b", i, d_vld, exp_v); end
      if (exp_v) begin
        n_checks++; if (d_aud !== 24'd250) begin n_fail++; $display("FAIL mask_audio got %h exp %h", d_aud, 24'd250); end
      end
      valid = (i == 0);
      audio = {24'h123456, 24'h123456, 24'h123456, 24'd1000};
    end
    n_checks++; if (d_prm !== 1'b1) begin n_fail++; $display("FAIL mask_primed got %b exp 1", d_prm); end
  endtask

  task automatic test_saturation();
    logic [23:0] in_v [4];
    logic [23:0] exp_a [4];
    logic        exp_s [4];
    int          j;
    in_v[0] = 24'h7fffff; exp_a[0] = 24'h7fffff; exp_s[0] = 1'b1;
    in_v[1] = 24'h800000; exp_a[1] = 24'h800000; exp_s[1] = 1'b1;
    in_v[2] = 24'h000001; exp_a[2] = 24'h000004; exp_s[2] = 1'b0;
    in_v[3] = 24'hffffff; exp_a[3] = 24'hfffffc; exp_s[3] = 1'b0;
    do_reset();
    n_checks++; if (s_prm !== 1'b1) begin n_fail++; $display("FAIL sat_primed got %b exp 1", s_prm); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      j = i - 3;
      if (j >= 0) begin
        n_checks++; if (s_vld !== 1'b1) begin n_fail++; $display("FAIL sat_valid j=%0d got %b exp 1", j, s_vld); end
        n_checks++; if (s_aud !== exp_a[j]) begin n_fail++; $display("FAIL sat_audio j=%0d got %h exp %h", j, s_aud, exp_a[j]); end
        n_checks++; if (s_sat !== exp_s[j]) begin n_fail++; $display("FAIL sat_flag j=%0d got %b exp %b", j, s_sat, exp_s[j]); end
        if (j == 0) begin
          // Shift by two keeps the full-scale sum in range on the default build.
          n_checks++; if (d_aud !== 24'h7fffff || d_sat !== 1'b0) begin
            n_fail++; $display("FAIL sat_shifted got %h/%b exp 7fffff/0", d_aud, d_sat);
          end
        end
      end
      valid = (i < 4);
      audio = all4(in_v[i % 4]);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_a;
    logic        exp_v;
    int          j;
    do_reset();
    do_load('0, {4{4'd15}}, 4'hf);
    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      j     = i - 3;
      exp_v = (j >= 15) && (j < 40);
      n_checks++; if (w_vld !== exp_v) begin n_fail++; $display("FAIL wrap_valid j=%0d got %b exp %b", j, w_vld, exp_v); end
      if (exp_v) begin
        exp_a = 24'(j - 15);
        n_checks++; if (w_aud !== exp_a || w_sat !== 1'b0) begin
          n_fail++; $display("FAIL wrap_audio j=%0d got %h/%b exp %h/0", j, w_aud, w_sat, exp_a);
        end
      end
      valid = (i < 40);
      audio = all4(24'(i));
    end
    n_checks++; if (w_prm !== 1'b1) begin n_fail++; $display("FAIL wrap_primed got %b exp 1", w_prm); end
  endtask

  task automatic test_live_reload();
    logic [23:0] exp_a;
    logic        exp_v;
    int          j;
    do_reset();
    do_load(pk(0, 2, 0, 0), '0, 4'b0010);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      j     = i - 3;
      exp_v = (j >= 2) && (j < 22);
      n_checks++; if (d_vld !== exp_v) begin n_fail++; $display("FAIL reload_valid j=%0d got %b exp %b", j, d_vld, exp_v); end
      if (exp_v) begin
        exp_a = (j == 21) ? 24'd11 : 24'(j - 2);
        n_checks++; if (d_aud !== exp_a) begin n_fail++; $display("FAIL reload_audio j=%0d got %h exp %h", j, d_aud, exp_a); end
      end
      if (i == 22) begin
        n_checks++; if (d_prm !== 1'b1) begin n_fail++; $display("FAIL reload_primed got %b exp 1", d_prm); end
      end
      valid  = (i < 22);
      audio  = all4(24'(4 * i));
      load   = (i == 20);
      delays = (i >= 20) ? pk(0, 10, 0, 0) : pk(0, 2, 0, 0);
    end
  endtask

  task automatic test_reset_midstream();
    logic [23:0] exp_a;
    logic        exp_v;
    int          j;
    do_reset();
    do_load(pk(0, 1, 2, 3), '0, 4'hf);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      j     = i - 3;
      exp_v = (j >= 3);
      n_checks++; if (d_vld !== exp_v) begin n_fail++; $display("FAIL midrst_pre_valid j=%0d got %b exp %b", j, d_vld, exp_v); end
      valid = (i < 8);
      audio = all4(24'(4 * i));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (d_vld !== 1'b0 || d_aud !== 24'h0 || d_prm !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear got v=%b a=%h p=%b exp 0/000000/0", d_vld, d_aud, d_prm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_load(pk(0, 1, 2, 3), '0, 4'hf);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      j     = i - 3;
      exp_v = (j >= 3) && (j < 6);
      n_checks++; if (d_vld !== exp_v) begin n_fail++; $display("FAIL midrst_valid j=%0d got %b exp %b", j, d_vld, exp_v); end
      if (exp_v) begin
        exp_a = 24'(4 * j - 6);
        n_checks++; if (d_aud !== exp_a) begin n_fail++; $display("FAIL midrst_audio j=%0d got %h exp %h", j, d_aud, exp_a); end
      end
      valid = (i < 6);
      audio = all4(24'(4 * i));
    end
  endtask

  initial begin
    test_reset();
    test_basic_delay();
    test_masking();
    test_saturation();
    test_wrap();
    test_live_reload();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
